// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: deserialized TMDS word in, decoded video/control and alignment status out
interface tmds_channel_decoder_if;
   logic [9:0] raw_word;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       active;
   logic       locked;
   logic [3:0] offset;
   modport master (output raw_word, input data, ctrl, active, locked, offset);
   modport slave  (input raw_word, output data, ctrl, active, locked, offset);
endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word-aligns a TMDS channel on control tokens and decodes pixel/control words
module tmds_channel_decoder #(
   parameter int LOCK_RUN   = 16,
   parameter int MISS_LIMIT = 1024
) (
   input logic pclk,
   input logic reset,
   tmds_channel_decoder_if.slave bus
);
   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;
   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t      state;
   logic [9:0]  prev_q, win_q, window;
   logic [19:0] cat;
   logic [4:0]  run;
   logic [10:0] miss;
   logic        is_tok, run_hit, miss_hit;
   logic [1:0]  tok_val;
   logic [7:0]  b, dec;
   logic [3:0]  next_off;
   // window extraction, token classification and pixel decode of the stage-1 word
   always_comb begin
      cat      = {bus.raw_word, prev_q};
      window   = 10'(cat >> bus.offset);
      is_tok   = win_q inside {TOK00, TOK01, TOK10, TOK11};
      tok_val  = (win_q == TOK01) ? 2'b01 : (win_q == TOK10) ? 2'b10 : (win_q == TOK11) ? 2'b11 : 2'b00;
      b        = win_q[9] ? ~win_q[7:0] : win_q[7:0];
      dec      = '0;
      dec[0]   = b[0];
      for (int i = 1; i < 8; i++) dec[i] = win_q[8] ? b[i] ^ b[i-1] : ~(b[i] ^ b[i-1]);
      run_hit  = int'(run) + 1 == LOCK_RUN;
      miss_hit = int'(miss) + 1 == MISS_LIMIT;
      next_off = (bus.offset == 4'd9) ? 4'd0 : bus.offset + 4'd1;
   end
   // pipeline registers, search/lock state machine and registered outputs
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         prev_q     <= '0;
         win_q      <= '0;
         run        <= '0;
         miss       <= '0;
         bus.data   <= '0;
         bus.ctrl   <= '0;
         bus.active <= 1'b0;
         bus.locked <= 1'b0;
         bus.offset <= '0;
      end else begin
         prev_q     <= bus.raw_word;
         win_q      <= window;
         bus.data   <= '0;
         bus.ctrl   <= '0;
         bus.active <= 1'b0;
         if (state == SEARCH) begin
            if (is_tok) begin
               miss <= '0;
               run  <= run_hit ? '0 : (&run ? run : run + 5'd1);
               if (run_hit) begin
                  state      <= LOCKED;
                  bus.locked <= 1'b1;
               end
            end else begin
               run  <= '0;
               miss <= miss_hit ? '0 : miss + 11'd1;
               if (miss_hit) bus.offset <= next_off;
            end
         end else if (is_tok) begin
            miss     <= '0;
            bus.ctrl <= tok_val;
         end else if (miss_hit) begin
            state      <= SEARCH;
            bus.locked <= 1'b0;
            bus.offset <= next_off;
            run        <= '0;
            miss       <= '0;
         end else begin
            miss       <= miss + 11'd1;
            bus.active <= 1'b1;
            bus.data   <= dec;
         end
      end
   end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: scenario tasks against a behavioural model of alignment and decode
module tb_tmds_channel_decoder;
   logic pclk = 1'b0;
   logic reset = 1'b0;
   bit clk_run = 1'b0;
   int checks = 0;
   int failures = 0;
   tmds_channel_decoder_if bus();
   tmds_channel_decoder dut (.pclk(pclk), .reset(reset), .bus(bus));
   always #20 if (clk_run) pclk = ~pclk;
   logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   localparam logic [9:0] PA = 10'b0100000000;
   localparam logic [9:0] PB = 10'b1000000000;
   localparam logic [9:0] Z = 10'b0000000000;
   logic [9:0] last_enc = '0;
   int shift_k = 0;
   int lpos = 0;
   int m_prev, m_win, m_off, m_run, m_miss, e_data, e_ctrl;
   bit m_lock, e_act;

   function automatic int tok_of(int w);
      for (int i = 0; i < 4; i++) if (w == int'(toks[i])) return i;
      return -1;
   endfunction

   function automatic int dec_of(int q);
      int bb;
      bb = ((q >> 9) & 1) != 0 ? (~q & 255) : (q & 255);
      return (((bb ^ (bb << 1)) ^ (((q >> 8) & 1) != 0 ? 0 : 'hFE)) & 'hFE) | (bb & 1);
   endfunction

   function automatic logic [9:0] line_word(int p);
      return p < 160 ? toks[0] : ($urandom_range(1) != 0 ? PA : PB);
   endfunction

   task automatic model_reset();
      m_prev = 0; m_win = 0; m_off = 0; m_run = 0; m_miss = 0; m_lock = 0;
      e_data = 0; e_ctrl = 0; e_act = 0;
   endtask

   task automatic model_step(input int r);
      int t, nw;
      t = tok_of(m_win);
      nw = (((r << 10) | m_prev) >> m_off) & 1023;
      e_data = 0; e_ctrl = 0; e_act = 0;
      if (!m_lock) begin
         if (t >= 0) begin
            m_miss = 0;
            if (m_run + 1 == 16) begin m_lock = 1; m_run = 0; end
            else m_run = (m_run == 31) ? 31 : m_run + 1;
         end else begin
            m_run = 0;
            m_miss++;
            if (m_miss == 1024) begin m_off = (m_off + 1) % 10; m_miss = 0; end
         end
      end else if (t >= 0) begin
         m_miss = 0;
         e_ctrl = t;
      end else begin
         m_miss++;
         if (m_miss == 1024) begin m_lock = 0; m_off = (m_off + 1) % 10; m_run = 0; m_miss = 0; end
         else begin e_act = 1; e_data = dec_of(m_win); end
      end
      m_prev = r;
      m_win = nw;
   endtask

   // present one encoded word on the wire at bit phase shift_k, step the model on the edge, return at negedge
   task automatic drive(input logic [9:0] w);
      logic [19:0] c;
      c = {w, last_enc};
      bus.raw_word = 10'(c >> (10 - shift_k));
      last_enc = w;
      @(posedge pclk);
      model_step(int'(bus.raw_word));
      @(negedge pclk);
   endtask

   task automatic test_reset();
      bus.raw_word = '0;
      #1 reset = 1'b1;
      #2;
      model_reset();
      checks++;
      if (bus.data !== 8'h00 || bus.ctrl !== 2'b00 || bus.active !== 1'b0 || bus.locked !== 1'b0 || bus.offset !== 4'd0) begin
         failures++;
         $display("FAIL reset_noclk: data=%h ctrl=%b active=%b locked=%b offset=%0d required all zero", bus.data, bus.ctrl, bus.active, bus.locked, bus.offset);
      end
      clk_run = 1'b1;
      @(negedge pclk);
      reset = 1'b0;
   endtask

   task automatic test_decode();
      shift_k = 0;
      last_enc = '0;
      repeat (16) drive(toks[0]);
      drive(PA);
      checks++;
      if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_after_15: locked=%b required 0", bus.locked); end
      drive(PB);
      checks++;
      if (bus.locked !== 1'b1 || bus.active !== 1'b0 || bus.ctrl !== 2'b00) begin
         failures++;
         $display("FAIL lock_after_16: locked=%b active=%b ctrl=%b required 1 0 00", bus.locked, bus.active, bus.ctrl);
      end
      drive(toks[0]);
      checks++;
      if (bus.data !== 8'h00 || bus.active !== 1'b1 || bus.ctrl !== 2'b00) begin
         failures++;
         $display("FAIL pix_0100000000: data=%h active=%b ctrl=%b required 00 1 00", bus.data, bus.active, bus.ctrl);
      end
      drive(toks[1]);
      checks++;
      if (bus.data !== 8'hFF || bus.active !== 1'b1 || bus.ctrl !== 2'b00) begin
         failures++;
         $display("FAIL pix_1000000000: data=%h active=%b ctrl=%b required ff 1 00", bus.data, bus.active, bus.ctrl);
      end
      for (int i = 0; i < 4; i++) begin
         drive(i < 2 ? toks[i + 2] : Z);
         checks++;
         if (bus.ctrl !== 2'(i) || bus.active !== 1'b0 || bus.data !== 8'h00) begin
            failures++;
            $display("FAIL token_%0d: ctrl=%b active=%b data=%h required %b 0 00", i, bus.ctrl, bus.active, bus.data, 2'(i));
         end
      end
   endtask

   task automatic test_random();
      logic [9:0] w;
      for (int n = 0; n < 400; n++) begin
         w = ($urandom_range(3) == 0) ? toks[$urandom_range(3)] : 10'($urandom);
         drive(w);
         checks++;
         if (bus.data !== 8'(e_data) || bus.ctrl !== 2'(e_ctrl) || bus.active !== e_act || bus.locked !== m_lock || bus.offset !== 4'(m_off)) begin
            failures++;
            $display("FAIL random_%0d: got data=%h ctrl=%b active=%b locked=%b offset=%0d required data=%h ctrl=%b active=%b locked=%b offset=%0d",
                     n, bus.data, bus.ctrl, bus.active, bus.locked, bus.offset, 8'(e_data), 2'(e_ctrl), e_act, m_lock, m_off);
         end
      end
   endtask

   task automatic test_align();
      int n;
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      shift_k = 3;
      last_enc = '0;
      lpos = 160;
      n = 0;
      while (bus.locked !== 1'b1 && n < 3200) begin
         drive(line_word(lpos));
         lpos = (lpos + 1) % 800;
         n++;
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.offset !== 4'd3) begin
         failures++;
         $display("FAIL align_lock: locked=%b offset=%0d after %0d words required 1 and 3 within 3200", bus.locked, bus.offset, n);
      end
      for (int i = 0; i < 30 * 800; i++) begin
         drive(line_word(lpos));
         lpos = (lpos + 1) % 800;
         checks++;
         if (bus.locked !== 1'b1 || bus.offset !== 4'd3 || bus.data !== 8'(e_data) || bus.active !== e_act || bus.ctrl !== 2'(e_ctrl)) begin
            failures++;
            $display("FAIL align_hold_%0d: locked=%b offset=%0d data=%h active=%b ctrl=%b required 1 3 %h %b %b",
                     i, bus.locked, bus.offset, bus.data, bus.active, bus.ctrl, 8'(e_data), e_act, 2'(e_ctrl));
         end
      end
   endtask

   task automatic test_midlock_reset();
      repeat (400) begin
         drive(line_word(lpos));
         lpos = (lpos + 1) % 800;
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.active !== 1'b1) begin
         failures++;
         $display("FAIL midlock_pre: locked=%b active=%b required 1 1", bus.locked, bus.active);
      end
      clk_run = 1'b0;
      #5 reset = 1'b1;
      #1;
      checks++;
      if (bus.data !== 8'h00 || bus.ctrl !== 2'b00 || bus.active !== 1'b0 || bus.locked !== 1'b0 || bus.offset !== 4'd0) begin
         failures++;
         $display("FAIL midlock_reset: data=%h ctrl=%b active=%b locked=%b offset=%0d required all zero", bus.data, bus.ctrl, bus.active, bus.locked, bus.offset);
      end
      model_reset();
      #5 clk_run = 1'b1;
      @(negedge pclk);
      reset = 1'b0;
      shift_k = 0;
      repeat (16) drive(toks[0]);
      drive(Z);
      checks++;
      if (bus.locked !== 1'b0) begin failures++; $display("FAIL relock_15: locked=%b required 0", bus.locked); end
      drive(Z);
      checks++;
      if (bus.locked !== 1'b1 || bus.offset !== 4'd0) begin
         failures++;
         $display("FAIL relock_16: locked=%b offset=%0d required 1 0", bus.locked, bus.offset);
      end
   endtask

   task automatic test_miss();
      int n;
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      shift_k = 9;
      last_enc = '0;
      n = 0;
      while (bus.locked !== 1'b1 && n < 12000) begin
         drive(toks[0]);
         n++;
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.offset !== 4'd9) begin
         failures++;
         $display("FAIL miss_lock9: locked=%b offset=%0d after %0d words required 1 9", bus.locked, bus.offset, n);
      end
      repeat (1025) drive(Z);
      checks++;
      if (bus.locked !== 1'b1 || bus.offset !== 4'd9) begin
         failures++;
         $display("FAIL miss_1023: locked=%b offset=%0d required 1 9", bus.locked, bus.offset);
      end
      drive(Z);
      checks++;
      if (bus.locked !== 1'b0 || bus.offset !== 4'd0 || bus.active !== 1'b0 || bus.data !== 8'h00 || bus.ctrl !== 2'b00) begin
         failures++;
         $display("FAIL miss_1024: locked=%b offset=%0d active=%b data=%h ctrl=%b required 0 0 0 00 00", bus.locked, bus.offset, bus.active, bus.data, bus.ctrl);
      end
      shift_k = 0;
      for (int i = 0; i < 18; i++) begin
         drive(i < 15 ? toks[0] : Z);
         checks++;
         if (bus.locked !== 1'b0 || bus.locked !== m_lock) begin
            failures++;
            $display("FAIL no_relock_15_%0d: locked=%b required 0", i, bus.locked);
         end
      end
      repeat (16) drive(toks[0]);
      drive(Z);
      drive(Z);
      checks++;
      if (bus.locked !== 1'b1 || bus.offset !== 4'd0) begin
         failures++;
         $display("FAIL relock_after_miss: locked=%b offset=%0d required 1 0", bus.locked, bus.offset);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_random();
      test_align();
      test_midlock_reset();
      test_miss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
